// File: rtl/adsr_envelope.sv
// Beat-timed ADSR amplitude envelope applied to a signed 16-bit sample stream.
// Optional macro ADSR_EXP_RELEASE_EN selects exponential release instead of linear.
module adsr_envelope #(
  parameter int SUSTAIN_LEVEL = 160,
  parameter int GAIN_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play_enable,
  input  logic signed [15:0] sample_in,
  input  logic        [5:0]  duration,
  input  logic        [3:0]  attack_time,
  input  logic        [3:0]  decay_time,
  input  logic        [3:0]  sustain_time,
  input  logic        [3:0]  release_time,
  input  logic               beat,
  input  logic               load_new_note,
  output logic signed [15:0] sample_out
);

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE, DONE} state_t;

  localparam logic [GAIN_W-1:0] GMAX       = '1;
  localparam logic [GAIN_W-1:0] SUS        = GAIN_W'(SUSTAIN_LEVEL);
  localparam logic [GAIN_W-1:0] DECAY_SPAN = GAIN_W'(255 - SUSTAIN_LEVEL);

  state_t            state, state_n;
  logic [GAIN_W-1:0] gain, gain_n;
  logic [GAIN_W-1:0] rel_start, rel_start_n;
  logic [5:0]        remaining, remaining_n;
  logic [3:0]        phase_cnt, phase_cnt_n;
  logic [3:0]        a_q, d_q, s_q, r_q;
  logic [3:0]        a_t, d_t, s_t, r_t, cur_t;
  logic              go, stepping, last, entered;

  function automatic logic [7:0] recip(input logic [3:0] t);
    case (t)
      4'd1:    recip = 8'd255;
      4'd2:    recip = 8'd127;
      4'd3:    recip = 8'd85;
      4'd4:    recip = 8'd63;
      4'd5:    recip = 8'd51;
      4'd6:    recip = 8'd42;
      4'd7:    recip = 8'd36;
      4'd8:    recip = 8'd31;
      4'd9:    recip = 8'd28;
      4'd10:   recip = 8'd25;
      4'd11:   recip = 8'd23;
      4'd12:   recip = 8'd21;
      4'd13:   recip = 8'd19;
      4'd14:   recip = 8'd18;
      4'd15:   recip = 8'd17;
      default: recip = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] scale(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    scale = p[15:8];
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    sat_sub = (a >= b) ? a - b : 8'd0;
  endfunction

  // On a load the freshly presented times drive the skip chain; latched copies arrive next cycle.
  assign go       = play_enable & load_new_note;
  assign stepping = play_enable & beat & ~load_new_note &
                    (state inside {ATTACK, DECAY, SUSTAIN, RELEASE});
  assign a_t = go ? attack_time  : a_q;
  assign d_t = go ? decay_time   : d_q;
  assign s_t = go ? sustain_time : s_q;
  assign r_t = go ? release_time : r_q;

  always_comb begin
    case (state)
      ATTACK:  cur_t = a_q;
      DECAY:   cur_t = d_q;
      SUSTAIN: cur_t = s_q;
      RELEASE: cur_t = r_q;
      default: cur_t = 4'd0;
    endcase
  end

  assign last = ({1'b0, phase_cnt} + 5'd1) == {1'b0, cur_t};

  always_comb begin
    state_n     = state;
    gain_n      = gain;
    rel_start_n = rel_start;
    remaining_n = remaining;
    phase_cnt_n = phase_cnt;
    entered     = 1'b0;

    if (go) begin
      gain_n      = '0;
      remaining_n = duration;
      phase_cnt_n = 4'd0;
      state_n     = (duration == 6'd0) ? DONE : ATTACK;
      entered     = 1'b1;
    end else if (stepping) begin
      case (state)
        ATTACK:  gain_n = last ? GMAX : sat_add(gain, recip(a_t));
        DECAY:   gain_n = last ? SUS  : sat_sub(gain, scale(DECAY_SPAN, recip(d_t)));
        SUSTAIN: gain_n = SUS;
        RELEASE: begin
`ifdef ADSR_EXP_RELEASE_EN
          // Exponential tail; the >>2 step never stalls because it floors at 1.
          gain_n = last ? '0 : gain - (((gain >> 2) == '0) ? {7'd0, (gain != '0)} : (gain >> 2));
`else
          gain_n = last ? '0 : sat_sub(gain, scale(rel_start, recip(r_t)));
`endif
        end
        default: gain_n = '0;
      endcase
      if (last) begin
        phase_cnt_n = 4'd0;
        entered     = 1'b1;
        case (state)
          ATTACK:  state_n = DECAY;
          DECAY:   state_n = SUSTAIN;
          SUSTAIN: state_n = RELEASE;
          default: state_n = DONE;
        endcase
      end else begin
        phase_cnt_n = phase_cnt + 4'd1;
      end
    end

    // Zero-length phases collapse in the same cycle, applying each target gain in order.
    if (entered) begin
      if (state_n == ATTACK && a_t == 4'd0) begin
        gain_n  = GMAX;
        state_n = DECAY;
      end
      if (state_n == DECAY && d_t == 4'd0) begin
        gain_n  = SUS;
        state_n = SUSTAIN;
      end
      if (state_n == SUSTAIN && s_t == 4'd0)
        state_n = RELEASE;
      if (state_n == RELEASE) begin
        if (r_t == 4'd0) begin
          gain_n  = '0;
          state_n = DONE;
        end else begin
          rel_start_n = gain_n;
        end
      end
    end

    // Note-length bookkeeping overrides the phase schedule.
    if (stepping) begin
      remaining_n = (remaining == 6'd0) ? 6'd0 : remaining - 6'd1;
      if (remaining_n == 6'd0) begin
        state_n = DONE;
        gain_n  = '0;
      end else if (remaining_n == {2'b00, r_t} &&
                   state_n inside {ATTACK, DECAY, SUSTAIN}) begin
        state_n     = RELEASE;
        rel_start_n = gain_n;
        phase_cnt_n = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gain      <= '0;
      rel_start <= '0;
      remaining <= 6'd0;
      phase_cnt <= 4'd0;
      a_q       <= 4'd0;
      d_q       <= 4'd0;
      s_q       <= 4'd0;
      r_q       <= 4'd0;
    end else begin
      state     <= state_n;
      gain      <= gain_n;
      rel_start <= rel_start_n;
      remaining <= remaining_n;
      phase_cnt <= phase_cnt_n;
      if (go) begin
        a_q <= attack_time;
        d_q <= decay_time;
        s_q <= sustain_time;
        r_q <= release_time;
      end
    end
  end

  logic signed [24:0] prod;
  assign prod = sample_in * $signed({1'b0, gain});

  always_ff @(posedge clk) begin
    if (reset)             sample_out <= '0;
    else if (!play_enable) sample_out <= '0;
    else                   sample_out <= prod[23:8];
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed scoreboard bench for adsr_envelope (linear release build).
module tb_adsr_envelope;
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               play_enable = 1'b1;
  logic signed [15:0] sample_in = 16'sh4000;
  logic        [5:0]  duration = '0;
  logic        [3:0]  attack_time = '0, decay_time = '0, sustain_time = '0, release_time = '0;
  logic               beat = 1'b0;
  logic               load_new_note = 1'b0;
  logic signed [15:0] sample_out;

  int vectors = 0;
  int miscompares = 0;
  logic signed [15:0] sb[$];
  logic signed [15:0] exp_v;

  adsr_envelope dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .sample_in(sample_in),
    .duration(duration), .attack_time(attack_time), .decay_time(decay_time),
    .sustain_time(sustain_time), .release_time(release_time), .beat(beat),
    .load_new_note(load_new_note), .sample_out(sample_out)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] eo(input int s, input int g);
    int p;
    p = s * g;
    return 16'(p >>> 8);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int g);
    sb.push_back(eo(int'(sample_in), g));
  endtask

  task automatic check(input string tag);
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, sample_out=%0d", tag, sample_out);
    end else begin
      exp_v = sb.pop_front();
      vectors++;
      assert (sample_out === exp_v) else begin
        miscompares++;
        $error("FAIL %s: sample_out=%0d expected %0d", tag, sample_out, exp_v);
      end
    end
  endtask

  task automatic do_beat(input int g, input string tag);
    push(g);
    beat = 1'b1;
    cyc();
    beat = 1'b0;
    cyc();
    check(tag);
  endtask

  task automatic do_load(input int dur, input int a, input int d, input int s, input int r,
                         input int g, input string tag);
    duration = 6'(dur); attack_time = 4'(a); decay_time = 4'(d);
    sustain_time = 4'(s); release_time = 4'(r);
    push(g);
    load_new_note = 1'b1;
    cyc();
    load_new_note = 1'b0;
    cyc();
    check(tag);
  endtask

  task automatic idle(input int g, input string tag);
    push(g);
    cyc();
    check(tag);
  endtask

  int full_seq[16] = '{63, 126, 189, 255, 232, 209, 186, 160,
                       160, 160, 160, 160, 121, 82, 43, 0};
  int short_seq[6] = '{63, 126, 95, 64, 33, 0};

  initial begin
    // Reset held for 5 cycles with a live input sample
    for (int i = 0; i < 5; i++) begin
      sb.push_back(16'sd0);
      cyc();
      check("reset");
    end
    reset = 1'b0;
    idle(0, "idle_after_reset");

    // Full A=D=S=R=4 envelope over 16 beats; one sustain beat uses a negative sample
    do_load(16, 4, 4, 4, 4, 0, "load_full");
    for (int i = 0; i < 16; i++) begin
      sample_in = (i == 8) ? -16'sd16384 : 16'sh4000;
      do_beat(full_seq[i], $sformatf("full_beat%0d", i + 1));
    end
    sample_in = 16'sh4000;
    idle(0, "done_hold");
    do_beat(0, "done_beat");

    // Short note forces early release from mid-attack
    do_load(6, 4, 4, 4, 4, 0, "load_short");
    for (int i = 0; i < 6; i++)
      do_beat(short_seq[i], $sformatf("short_beat%0d", i + 1));
    do_beat(0, "short_done");

    // Zero attack and decay jump straight to sustain; reload mid-sustain restarts attack
    do_load(20, 0, 0, 4, 4, 160, "skip_ad");
    do_beat(160, "skip_sus1");
    do_beat(160, "skip_sus2");
    do_load(16, 4, 4, 4, 4, 0, "reload_mid_sus");
    do_beat(63, "reload_beat1");
    do_beat(126, "reload_beat2");

    // Pause mid-attack: muted, beats and loads ignored, gain frozen
    play_enable = 1'b0;
    idle(0, "pause_mute");
    for (int i = 0; i < 10; i++)
      do_beat(0, $sformatf("pause_beat%0d", i + 1));
    do_load(3, 1, 1, 1, 1, 0, "pause_load_ignored");
    play_enable = 1'b1;
    idle(126, "resume_frozen");
    do_beat(189, "resume_beat");

    // Zero-duration note goes directly to DONE
    do_load(0, 4, 4, 4, 4, 0, "dur_zero");
    do_beat(0, "dur_zero_beat");

    // Reset in the middle of a note
    do_load(16, 4, 4, 4, 4, 0, "load_pre_reset");
    do_beat(63, "pre_reset_beat");
    reset = 1'b1;
    sb.push_back(16'sd0);
    cyc();
    check("mid_reset");
    reset = 1'b0;
    idle(0, "post_reset_idle");
    do_beat(0, "post_reset_beat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
